float_round_pipe: RTL and testbench

- Parametrised, pipelined rounding and post-normalisation stage for the float datapath. Sits after the add/mul fraction stage and before result packing.
- Accepts sign, exponent and an extended fraction carrying guard/round/sticky bits; outputs a packed-ready sign/exponent/mantissa.
- Generalises the single-mode combinational rounder: adds four rounding modes, width parameters, exponent-overflow handling and a 2-stage valid/ready pipeline with backpressure.

---
 rtl/float_round_pipe.sv | 177 +++++++++++++++++
 tb/tb_float_round_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_round_pipe.sv
// float_round_pipe: two-stage rounding and post-normalisation for the float
// datapath. Stage 1 pre-shifts an overflowed fraction and applies the rounding
// increment; stage 2 renormalises on carry and clamps exponent overflow to
// infinity or max-finite according to the rounding mode.
// Optional build macro ROUND_INEXACT_FLAG_EN adds the out_inexact output.
module float_round_pipe #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W+4:0] in_frac,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_ovf
`ifdef ROUND_INEXACT_FLAG_EN
    ,
    output logic              out_inexact
`endif
);

    // Two spare exponent bits absorb the pre-shift and carry increments.
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    localparam logic [1:0] MODE_RNE = 2'b00;
    localparam logic [1:0] MODE_RTZ = 2'b01;
    localparam logic [1:0] MODE_RUP = 2'b10;

    function automatic logic round_up(input logic [1:0] mode, input logic sign,
                                      input logic lsb, input logic g,
                                      input logic r, input logic s);
        case (mode)
            MODE_RNE: return g & (r | s | lsb);
            MODE_RTZ: return 1'b0;
            MODE_RUP: return !sign & (g | r | s);
            default:  return sign & (g | r | s);
        endcase
    endfunction

    // Overflow saturates to infinity when the mode rounds away from zero
    // in the direction of the sign; otherwise to the largest finite value.
    function automatic logic ovf_to_inf(input logic [1:0] mode, input logic sign);
        case (mode)
            MODE_RNE: return 1'b1;
            MODE_RTZ: return 1'b0;
            MODE_RUP: return !sign;
            default:  return sign;
        endcase
    endfunction

    logic              vld_p1, vld_p2;
    logic              adv_p1;

    logic [MANT_W+3:0] norm;
    logic [MANT_W:0]   hm;
    logic              grd, rnd, stk, up;
    logic [XW-1:0]     exp_d;
    logic              carry_d, zero_d;
    logic [MANT_W-1:0] mant_d;

    logic              sign_p1, carry_p1, zero_p1;
    logic [1:0]        mode_p1;
    logic [XW-1:0]     exp_p1;
    logic [MANT_W-1:0] mant_p1;

    logic [XW-1:0]     exp_fin;
    logic [EXP_W-1:0]  res_exp;
    logic [MANT_W-1:0] res_mant;
    logic              res_ovf;

`ifdef ROUND_INEXACT_FLAG_EN
    logic              inexact_d, inexact_p1;
`endif

    assign adv_p1    = !vld_p2 | out_ready;
    assign in_ready  = !vld_p1 | adv_p1;
    assign out_valid = vld_p2;

    // Stage 1 combinational: pre-shift on O, pick rounding increment, add.
    always_comb begin
        norm    = in_frac[MANT_W+4] ? {in_frac[MANT_W+4:2], in_frac[1] | in_frac[0]}
                                    : in_frac[MANT_W+3:0];
        exp_d   = {2'b00, in_exp} + {{(XW-1){1'b0}}, in_frac[MANT_W+4]};
        hm      = norm[MANT_W+3:3];
        grd     = norm[2];
        rnd     = norm[1];
        stk     = norm[0];
        up      = round_up(in_mode, in_sign, hm[0], grd, rnd, stk);
        carry_d = up & (&hm);
        mant_d  = hm[MANT_W-1:0] + {{(MANT_W-1){1'b0}}, up};
        zero_d  = (in_frac == '0);
`ifdef ROUND_INEXACT_FLAG_EN
        inexact_d = grd | rnd | stk;
`endif
    end

    // Stage 1 valid: load whenever the stage can accept a new beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    // ---- stage 1 register boundary ----
    // Stage 1 data: captured on input transfer only.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sign_p1  <= in_sign;
            mode_p1  <= in_mode;
            exp_p1   <= exp_d;
            carry_p1 <= carry_d;
            mant_p1  <= mant_d;
            zero_p1  <= zero_d;
`ifdef ROUND_INEXACT_FLAG_EN
            inexact_p1 <= inexact_d;
`endif
        end
    end

    // Stage 2 combinational: renormalise on carry, then clamp overflow.
    always_comb begin
        exp_fin  = exp_p1 + {{(XW-1){1'b0}}, carry_p1};
        res_exp  = exp_fin[EXP_W-1:0];
        res_mant = carry_p1 ? '0 : mant_p1;
        res_ovf  = 1'b0;
        if (zero_p1) begin
            res_exp  = '0;
            res_mant = '0;
        end else if (exp_fin >= EXP_MAX) begin
            res_ovf = 1'b1;
            if (ovf_to_inf(mode_p1, sign_p1)) begin
                res_exp  = '1;
                res_mant = '0;
            end else begin
                res_exp  = {{(EXP_W-1){1'b1}}, 1'b0};
                res_mant = '1;
            end
        end
    end

    // ---- stage 2 register boundary ----
    // Output register: holds while downstream stalls, reset to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2   <= 1'b0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_mant <= '0;
            out_ovf  <= 1'b0;
`ifdef ROUND_INEXACT_FLAG_EN
            out_inexact <= 1'b0;
`endif
        end else if (adv_p1) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_sign <= sign_p1;
                out_exp  <= res_exp;
                out_mant <= res_mant;
                out_ovf  <= res_ovf;
`ifdef ROUND_INEXACT_FLAG_EN
                out_inexact <= inexact_p1 | res_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_float_round_pipe.sv
// Scoreboard bench for float_round_pipe (MANT_W=23, EXP_W=8): directed
// vectors with hand-derived results, then randomized traffic against an
// arithmetic reference model, plus handshake, backpressure and reset checks.
module tb_float_round_pipe;

    typedef struct packed {
        logic        sign;
        logic [7:0]  e;
        logic [22:0] m;
        logic        ovf;
        logic        inx;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_frac;
    logic [1:0]  in_mode;
    logic        out_valid, out_ready, out_sign, out_ovf;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
`ifdef ROUND_INEXACT_FLAG_EN
    logic        out_inexact;
`endif

    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    float_round_pipe #(.MANT_W(23), .EXP_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_ovf(out_ovf)
`ifdef ROUND_INEXACT_FLAG_EN
        , .out_inexact(out_inexact)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [27:0] mk(input logic o, input logic h, input logic [22:0] m,
                                       input logic g, input logic r, input logic s);
        return {o, h, m, g, r, s};
    endfunction

    function automatic res_t rr(input logic s, input logic [7:0] e, input logic [22:0] m,
                                input logic ovf, input logic inx);
        res_t x;
        x.sign = s; x.e = e; x.m = m; x.ovf = ovf; x.inx = inx;
        return x;
    endfunction

    // Reference: the fraction is an integer in units of 2^-3 (or 2^-4 when the
    // overflow bit is set); round the quotient by the remainder, then fold a
    // carry into the exponent and saturate.
    function automatic res_t model(input logic s, input logic [7:0] e_in,
                                   input logic [27:0] f, input logic [1:0] md);
        res_t   r;
        longint q, rem, half, fl;
        int     sh, e;
        bit     up, to_inf;
        r.sign = s;
        if (f == 0) begin
            r.e = 0; r.m = 0; r.ovf = 0; r.inx = 0;
            return r;
        end
        fl   = longint'(f);
        sh   = f[27] ? 4 : 3;
        e    = int'(e_in) + (f[27] ? 1 : 0);
        q    = fl >> sh;
        rem  = fl % (64'sd1 << sh);
        half = 64'sd1 << (sh - 1);
        case (md)
            2'd0:    up = (rem > half) || (rem == half && (q % 2) == 1);
            2'd1:    up = 0;
            2'd2:    up = !s && rem != 0;
            default: up = s && rem != 0;
        endcase
        if (up) q = q + 1;
        if (q >= (64'sd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        r.inx = (rem != 0);
        r.ovf = 0;
        if (e >= 255) begin
            to_inf = (md == 2'd0) || (md == 2'd2 && !s) || (md == 2'd3 && s);
            r.ovf = 1;
            r.inx = 1;
            r.e   = to_inf ? 8'hFF : 8'hFE;
            r.m   = to_inf ? 23'h0 : 23'h7FFFFF;
        end else begin
            r.e = 8'(e);
            r.m = 23'(q);
        end
        return r;
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for acceptance, push its expectation.
    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] f,
                        input logic [1:0] md, input res_t ex);
        int n = 0;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f; in_mode = md;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept at %0t", $time);
        end else begin
            exp_q.push_back(ex);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic s, input logic [7:0] e, input logic [27:0] f,
                          input logic [1:0] md);
        send(s, e, f, md, model(s, e, f, md));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    function automatic logic [27:0] rand_frac();
        logic [27:0] f;
        logic [2:0]  grs;
        f   = 28'($urandom);
        grs = 3'($urandom);
        case ($urandom_range(0, 5))
            0: ;
            1: f[27:26] = 2'b01;
            2: f = mk(1'b0, 1'b1, 23'h7FFFFF, grs[2], grs[1], grs[0]);
            3: f = '0;
            4: f[27] = 1'b1;
            default: f[27:26] = 2'b00;
        endcase
        return f;
    endfunction

    // Output monitor: pops and compares each delivered beat, and verifies that
    // a stalled output stays frozen until it is taken.
    initial begin
        res_t exp_v, held;
        bit   hold = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_sign", out_sign, held.sign);
                check("hold_exp", out_exp, held.e);
                check("hold_mant", out_mant, held.m);
                check("hold_ovf", out_ovf, held.ovf);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=exp%0h_mant%0h required=none at %0t",
                             out_exp, out_mant, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("beat_sign", out_sign, exp_v.sign);
                    check("beat_exp", out_exp, exp_v.e);
                    check("beat_mant", out_mant, exp_v.m);
                    check("beat_ovf", out_ovf, exp_v.ovf);
`ifdef ROUND_INEXACT_FLAG_EN
                    check("beat_inexact", out_inexact, exp_v.inx);
`endif
                end
            end
            hold = out_valid && !out_ready;
            held = rr(out_sign, out_exp, out_mant, out_ovf, 1'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sent, cyc;
        bit   acc_last;
        logic [27:0] f;
        int   acc0;

        reset_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
        in_frac = '0; in_mode = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sign", out_sign, 0);
        check("rst_out_exp", out_exp, 0);
        check("rst_out_mant", out_mant, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        reset_n = 1'b1;
        align();
        check("rst_in_ready", in_ready, 1);

        // RNE tie to even, with latency measured from the accept edge.
        send(1'b0, 8'h80, mk(0, 1, 23'h000001, 1, 0, 0), 2'd0, rr(0, 8'h80, 23'h000002, 0, 1));
        @(negedge clk);
        check("latency_c1", out_valid, 0);
        @(negedge clk);
        check("latency_c2", out_valid, 1);
        align();

        // Directed vectors, issued back to back.
        send(1'b0, 8'h7F, mk(0, 1, 23'h7FFFFF, 1, 0, 1), 2'd0, rr(0, 8'h80, 23'h0, 0, 1));
        send(1'b0, 8'hFE, mk(0, 1, 23'h7FFFFF, 1, 0, 0), 2'd0, rr(0, 8'hFF, 23'h0, 1, 1));
        send(1'b0, 8'hFE, mk(0, 1, 23'h7FFFFF, 1, 0, 0), 2'd1, rr(0, 8'hFE, 23'h7FFFFF, 0, 1));
        send(1'b1, 8'h40, mk(0, 1, 23'h000010, 0, 0, 1), 2'd3, rr(1, 8'h40, 23'h000011, 0, 1));
        send(1'b1, 8'h40, mk(0, 1, 23'h000010, 0, 0, 1), 2'd2, rr(1, 8'h40, 23'h000010, 0, 1));
        send(1'b0, 8'hFE, mk(1, 1, 23'h0, 0, 0, 0), 2'd1, rr(0, 8'hFE, 23'h7FFFFF, 1, 1));
        send(1'b1, 8'hFF, mk(0, 1, 23'h000123, 0, 0, 0), 2'd2, rr(1, 8'hFE, 23'h7FFFFF, 1, 1));
        send(1'b1, 8'hFF, mk(0, 1, 23'h000123, 0, 0, 0), 2'd3, rr(1, 8'hFF, 23'h0, 1, 1));
        send(1'b1, 8'h55, 28'h0, 2'd0, rr(1, 8'h00, 23'h0, 0, 0));
        send(1'b0, 8'h10, mk(0, 0, 23'h000005, 0, 0, 0), 2'd0, rr(0, 8'h10, 23'h000005, 0, 0));
        send(1'b0, 8'h20, mk(1, 0, 23'h000003, 0, 0, 0), 2'd0, rr(0, 8'h21, 23'h000002, 0, 1));
        drain();

        // Backpressure: stall the output for three cycles while streaming four beats.
        align();
        out_ready = 1'b0;
        acc0 = acc_cnt;
        send_m(1'b0, 8'h11, mk(0, 1, 23'h000101, 0, 0, 0), 2'd0);
        send_m(1'b0, 8'h12, mk(0, 1, 23'h000202, 0, 0, 0), 2'd0);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h13;
        in_frac = mk(0, 1, 23'h000303, 0, 0, 0); in_mode = 2'd0;
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", acc_cnt - acc0, 2);
        align();
        out_ready = 1'b1;
        send_m(1'b0, 8'h13, mk(0, 1, 23'h000303, 0, 0, 0), 2'd0);
        send_m(1'b0, 8'h14, mk(0, 1, 23'h000404, 0, 0, 0), 2'd0);
        drain();
        check("bp_total", acc_cnt - acc0, 4);

        // Randomized traffic with random output stalls.
        sent = 0;
        acc_last = 0;
        cyc = 0;
        while (sent < 400 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc_last) begin
                if ($urandom_range(0, 4) != 0) begin
                    f = rand_frac();
                    in_frac = f;
                    in_sign = 1'($urandom);
                    in_mode = 2'($urandom);
                    in_exp  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(250, 255))
                                                          : 8'($urandom_range(0, 255));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            acc_last = in_valid && in_ready;
            if (acc_last) begin
                exp_q.push_back(model(in_sign, in_exp, in_frac, in_mode));
                sent++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", sent, 400);
        drain();

        // Reset with two beats in flight: they must vanish.
        align();
        out_ready = 1'b0;
        send_m(1'b0, 8'h30, mk(0, 1, 23'h00ABCD, 1, 1, 0), 2'd0);
        send_m(1'b1, 8'h31, mk(0, 1, 23'h001234, 0, 1, 1), 2'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end
        check("rst_mid_exp", out_exp, 0);
        check("rst_mid_mant", out_mant, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
